keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- Reads a 4x4 matrix keypad, the input-side counterpart of the 4-digit SSD scan driver.
- Drives one-cold column strobes using the same 0111/1011/1101/1110 rotation as the display scan.
- Samples the active-low rows, decodes one key per full scan and debounces it.
- Issues a single-cycle key_valid pulse and a held key_code to downstream lab logic (SSD display path, FSMs).

Parameters:
SCAN_DIV, 50000, clk cycles each column is driven (dwell); minimum 4
DEBOUNCE_SCANS, 4, consecutive identical full-scan results needed to accept a press or release; minimum 1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
row_in  input  4  keypad rows, active-low, externally pulled up; row index 0 = row_in[3] ... index 3 = row_in[0]
col_out  output  4  column strobe, one-cold; col idx0=4'b0111, idx1=4'b1011, idx2=4'b1101, idx3=4'b1110
key_code  output  4  {row_idx[1:0], col_idx[1:0]} of last accepted key; held until next accept
key_valid  output  1  one-cycle pulse when a press is accepted
key_down  output  1  high from press acceptance until release acceptance

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst). All flops reset asynchronously.
- Reset values:
  - col_out=4'b0111 (idx0), key_code=4'h0, key_valid=0, key_down=0.
  - Dwell counter=0, debounce count=0, state IDLE, synchronizer flops=4'b1111.
- Scan:
  - row_in passes through a 2-flop synchronizer.
  - Dwell counter counts 0..SCAN_DIV-1. On terminal count it wraps, col idx increments mod 4 and col_out updates the next cycle.
  - Synchronized rows are sampled only on the terminal-count cycle of each dwell (settling margin ≥ SCAN_DIV-3 cycles).
- Scan result: accumulated over idx0..idx3 and evaluated on the terminal cycle of idx3 (scan end).
  - NONE: no low row seen.
  - SINGLE(code): exactly one low row in exactly one column; code = {row_idx, col_idx}.
  - MULTI: two or more lows anywhere. Treated as NONE in IDLE/DB_PRESS and as "not released" in PRESSED/DB_RELEASE.
- FSM (advances only at scan end):
  - IDLE:
    - SINGLE(c): cand=c, cnt=1. If DEBOUNCE_SCANS==1, accept immediately; otherwise go to DB_PRESS.
  - DB_PRESS:
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_SCANS, accept.
    - SINGLE(other): cand=other, cnt=1.
    - NONE/MULTI: back to IDLE.
  - Accept: next cycle key_code=cand, key_valid=1 for exactly one cycle, key_down=1, state PRESSED.
  - PRESSED:
    - NONE: cnt=1, go to DB_RELEASE (or release immediately if DEBOUNCE_SCANS==1).
    - Anything else: stay; no new pulse, even for a different key.
  - DB_RELEASE:
    - NONE: cnt++. At DEBOUNCE_SCANS, key_down=0 next cycle, state IDLE.
    - Any key: back to PRESSED.
- key_code is never cleared except by reset.
- Latency from scan end to key_valid is 1 cycle. Minimum press-to-pulse is DEBOUNCE_SCANS scans plus a ≤2-cycle synchronizer delay.
- Reset mid-operation: outputs take reset values immediately (asynchronously); scan restarts at idx0 with a fresh dwell.
- Counter widths: dwell uses $clog2(SCAN_DIV); debounce count uses $clog2(DEBOUNCE_SCANS+1). Wrap exactly at terminal values, no overflow.

Decomposition:
- Shared package keypad_pkg:
  - FSM state encodings (IDLE, DB_PRESS, PRESSED, DB_RELEASE).
  - Column strobe constants COL_PAT[0..3].
  - NUM_COLS=4, NUM_ROWS=4.
  - Scan-result encoding (NONE/SINGLE/MULTI).
- One sub-module: row_sync, a parameterised-width 2-flop synchronizer with async active-high reset to all-ones.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, full scan = 16 cycles):
1. Assert/release rst, row_in=4'b1111.
   - col_out=0111 for cycles 0-3, 1011 for 4-7, 1101 for 8-11, 1110 for 12-15, 0111 at 16.
   - key_valid and key_down stay 0.
2. Key row1/col2: drive row_in=4'b1011 whenever col_out==1101, hold 3 scans.
   - Exactly one key_valid pulse, 1 cycle after the 2nd stable scan end.
   - key_code=4'b0110, key_down=1.
3. Bounce: same key present for 1 scan, absent next, present again for 1 scan, then absent.
   - No key_valid; key_down stays 0.
4. After test 2, release (row_in=1111).
   - key_down falls 1 cycle after the 2nd clean scan end.
   - key_code stays 4'b0110; no key_valid.
5. Multi-key:
   - In IDLE, press row0/col0 and row3/col3 together for 4 scans: no key_valid.
   - In PRESSED on 4'b0110, add a second key: no new pulse, key_down stays 1.
6. Assert rst mid-dwell while PRESSED (col idx2): same cycle, col_out=0111, key_down=0, key_code=0. After deassert, scan restarts at idx0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_ROWS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DB_PRESS,
    ST_PRESSED,
    ST_DB_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SINGLE,
    RES_MULTI
  } scan_res_t;

  // One-cold strobe per column index, same rotation as the display scan.
  localparam logic [3:0] COL_PAT [NUM_COLS] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer, resets to all-ones (idle level of pulled-up rows).
module row_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with per-scan decode and debounce.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_TC  = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_TARGET = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [3:0] row_s;

  row_sync #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_in),
    .q   (row_s)
  );

  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    acc_cnt_q, acc_cnt_d;
  logic [3:0]    acc_code_q, acc_code_d;

  logic          tc;
  logic          scan_end;
  logic [3:0]    row_low;
  logic [2:0]    col_lows;
  logic [1:0]    row_hit;
  logic [2:0]    lows_sum;
  logic [1:0]    lows_sat;
  logic [3:0]    code_now;
  scan_res_t     scan_res;

  // Dwell counter, column rotation and per-scan low-row accumulation.
  always_comb begin
    tc        = (dwell_q == DWELL_TC);
    scan_end  = tc && (col_idx_q == 2'd3);
    dwell_d   = tc ? '0 : dwell_q + 1'b1;
    col_idx_d = tc ? col_idx_q + 1'b1 : col_idx_q;

    row_low  = ~row_s;
    col_lows = '0;
    row_hit  = '0;
    for (int unsigned b = 0; b < NUM_ROWS; b++) begin
      if (row_low[b]) begin
        col_lows = col_lows + 3'd1;
        row_hit  = 2'(NUM_ROWS - 1 - b);
      end
    end

    // Saturate at 2: anything beyond one low is simply "multi".
    lows_sum = {1'b0, acc_cnt_q} + col_lows;
    lows_sat = (lows_sum >= 3'd2) ? 2'd2 : lows_sum[1:0];
    code_now = (col_lows == 3'd1) ? {row_hit, col_idx_q} : acc_code_q;

    case (lows_sat)
      2'd0:    scan_res = RES_NONE;
      2'd1:    scan_res = RES_SINGLE;
      default: scan_res = RES_MULTI;
    endcase

    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (tc) begin
      if (scan_end) begin
        acc_cnt_d  = '0;
        acc_code_d = '0;
      end else begin
        acc_cnt_d  = lows_sat;
        acc_code_d = code_now;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q    <= '0;
      col_idx_q  <= '0;
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else begin
      dwell_q    <= dwell_d;
      col_idx_q  <= col_idx_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
    end
  end

  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_down_q, key_down_d;

  // Debounce FSM, advancing only on the scan-end cycle.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + 1'b1;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;

    if (scan_end) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_res == RES_SINGLE) begin
            cand_d = code_now;
            cnt_d  = CNT_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              key_code_d  = code_now;
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
              state_d     = ST_PRESSED;
            end else begin
              state_d = ST_DB_PRESS;
            end
          end
        end
        ST_DB_PRESS: begin
          if (scan_res == RES_SINGLE && code_now == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_TARGET) begin
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
              state_d     = ST_PRESSED;
            end
          end else if (scan_res == RES_SINGLE) begin
            cand_d = code_now;
            cnt_d  = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if (scan_res == RES_NONE) begin
            cnt_d = CNT_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              key_down_d = 1'b0;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_DB_RELEASE;
            end
          end
        end
        ST_DB_RELEASE: begin
          if (scan_res == RES_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_TARGET) begin
              key_down_d = 1'b0;
              state_d    = ST_IDLE;
            end
          end else begin
            state_d = ST_PRESSED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign col_out   = COL_PAT[col_idx_q];
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan with a behavioural key-matrix model.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;

  // keys[r*4+c] = key at row r, column c is held down
  logic [15:0] keys = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } exp_t;

  exp_t sbq[$];

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Pressed key pulls its row low while its column strobe is low.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && col_out[3-c] == 1'b0)
          row_in[3-r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Column strobe follows cycle count: 4 cycles per column.
  always @(negedge clk) begin
    if (!rst) begin
      logic [3:0] e;
      e = 4'b1111;
      e[3 - ((cyc / 4) % 4)] = 1'b0;
      check("col_out", {28'd0, col_out}, {28'd0, e});
    end
  end

  // Monitor: every key_valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && key_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_key_valid: actual=1 required=0 code=%0h (cyc %0d)", key_code, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("valid_code", {28'd0, key_code}, {28'd0, e.code});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    #1;
    check("rst_col_out", {28'd0, col_out}, 32'h7);
    check("rst_key_code", {28'd0, key_code}, 32'h0);
    check("rst_key_valid", {31'd0, key_valid}, 32'h0);
    check("rst_key_down", {31'd0, key_down}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // idle scan
    wait_until(16);
    check("t1_key_down", {31'd0, key_down}, 32'h0);

    // row1/col2 held three scans
    wait_until(32);
    keys = 16'h0040;
    sbq.push_back('{cyc: 64, code: 4'b0110});
    wait_until(70);
    check("t2_key_down", {31'd0, key_down}, 32'h1);
    check("t2_key_code", {28'd0, key_code}, 32'h6);

    // release
    wait_until(80);
    keys = '0;
    wait_until(111);
    check("t4_down_held", {31'd0, key_down}, 32'h1);
    wait_until(112);
    check("t4_down_fall", {31'd0, key_down}, 32'h0);
    check("t4_code_held", {28'd0, key_code}, 32'h6);

    // bounce: present, absent, present, absent
    wait_until(128);
    keys = 16'h0040;
    wait_until(144);
    keys = '0;
    wait_until(160);
    keys = 16'h0040;
    wait_until(176);
    keys = '0;
    wait_until(193);
    check("t3_key_down", {31'd0, key_down}, 32'h0);
    check("t3_key_code", {28'd0, key_code}, 32'h6);

    // two keys in IDLE: row0/col0 + row3/col3
    wait_until(208);
    keys = 16'h8001;
    wait_until(272);
    keys = '0;
    wait_until(273);
    check("t5a_key_down", {31'd0, key_down}, 32'h0);

    // press, then add a second key, then switch to a different single key
    wait_until(288);
    keys = 16'h0040;
    sbq.push_back('{cyc: 320, code: 4'b0110});
    wait_until(320);
    keys = 16'h0041;
    wait_until(351);
    check("t5b_down_multi", {31'd0, key_down}, 32'h1);
    wait_until(352);
    keys = 16'h0200;
    wait_until(376);
    check("t5b_down_other", {31'd0, key_down}, 32'h1);
    check("t5b_code_kept", {28'd0, key_code}, 32'h6);

    // asynchronous reset during column idx2 while pressed
    wait_until(377);
    rst = 1'b1;
    keys = '0;
    #1;
    check("t6_col_out", {28'd0, col_out}, 32'h7);
    check("t6_key_down", {31'd0, key_down}, 32'h0);
    check("t6_key_code", {28'd0, key_code}, 32'h0);
    check("t6_key_valid", {31'd0, key_valid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_until(20);
    check("t6_post_down", {31'd0, key_down}, 32'h0);

    check("sb_drained", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
